// File: rtl/sram_arb.sv
// sram_arb: two-requester round-robin arbiter in front of an SPI SRAM
// controller, plus a free-running advance strobe generator for that controller.
//
// Ports
//   i_clk, i_rst            clock; asynchronous active-high reset
//   i_a_* / i_b_*           requester side: valid, rd_n_wr (1 = read), addr, wdata
//   o_a_accept / o_b_accept one-cycle pulse when the request is captured
//   o_a_done / o_b_done     one-cycle completion pulse for that requester
//   o_a_rdata / o_b_rdata   last read data completed for that requester
//   o_advance               one-cycle strobe every DIV cycles (constant at DIV=1)
//   o_valid, o_rd_n_wr,
//   o_addr, o_wdata         request to the controller, held until i_accept
//   i_accept                controller took the request
//   i_ready, i_rdata        controller read completion and its data
//   o_busy                  arbiter is not idle
module sram_arb #(
    parameter int DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic        i_a_rd_n_wr,
    input  logic [15:0] i_a_addr,
    input  logic [7:0]  i_a_wdata,
    output logic        o_a_accept,
    output logic        o_a_done,
    output logic [7:0]  o_a_rdata,
    input  logic        i_b_valid,
    input  logic        i_b_rd_n_wr,
    input  logic [15:0] i_b_addr,
    input  logic [7:0]  i_b_wdata,
    output logic        o_b_accept,
    output logic        o_b_done,
    output logic [7:0]  o_b_rdata,
    output logic        o_advance,
    output logic        o_valid,
    input  logic        i_accept,
    output logic        o_rd_n_wr,
    output logic [15:0] o_addr,
    output logic [7:0]  o_wdata,
    input  logic        i_ready,
    input  logic [7:0]  i_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD
    } state_t;

    localparam logic [7:0] ADV_LAST = 8'(DIV - 1);

    state_t      r_state;
    logic [7:0]  r_adv_cnt;
    logic        r_advance;
    logic        r_last_b;      // last grant went to B; resets to B so A wins first
    logic        r_owner_b;     // owner of the transaction in flight
    logic        r_hold_rd_n_wr;
    logic [15:0] r_hold_addr;
    logic [7:0]  r_hold_wdata;
    logic        r_a_done;
    logic        r_b_done;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;

    logic        w_idle;
    logic        w_grant_a;
    logic        w_grant_b;

    // Advance strobe: the counter wraps at DIV-1 and the strobe is registered
    // on the wrap, so DIV=1 wraps every cycle and the strobe stays high.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_adv_cnt <= '0;
            r_advance <= 1'b0;
        end else if (r_adv_cnt == ADV_LAST) begin
            r_adv_cnt <= '0;
            r_advance <= 1'b1;
        end else begin
            r_adv_cnt <= r_adv_cnt + 8'd1;
            r_advance <= 1'b0;
        end
    end

    // Round-robin: with both valid, A wins only if B was granted last.
    assign w_idle    = (r_state == S_IDLE);
    assign w_grant_a = i_a_valid & (~i_b_valid | r_last_b);
    assign w_grant_b = i_b_valid & ~w_grant_a;

    // NOTE: the holding and rdata registers are reset as well as the FSM,
    // because they drive outputs that must read 0 while reset is asserted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_last_b       <= 1'b1;
            r_owner_b      <= 1'b0;
            r_hold_rd_n_wr <= 1'b0;
            r_hold_addr    <= '0;
            r_hold_wdata   <= '0;
            r_a_done       <= 1'b0;
            r_b_done       <= 1'b0;
            r_a_rdata      <= '0;
            r_b_rdata      <= '0;
        end else begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_owner_b      <= w_grant_b;
                        r_last_b       <= w_grant_b;
                        r_hold_rd_n_wr <= w_grant_b ? i_b_rd_n_wr : i_a_rd_n_wr;
                        r_hold_addr    <= w_grant_b ? i_b_addr    : i_a_addr;
                        r_hold_wdata   <= w_grant_b ? i_b_wdata   : i_a_wdata;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_accept) begin
                        if (r_hold_rd_n_wr) begin
                            r_state <= S_WAIT_RD;
                        end else begin
                            r_a_done <= ~r_owner_b;
                            r_b_done <= r_owner_b;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (i_ready) begin
                        if (r_owner_b) begin
                            r_b_rdata <= i_rdata;
                        end else begin
                            r_a_rdata <= i_rdata;
                        end
                        r_a_done <= ~r_owner_b;
                        r_b_done <= r_owner_b;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Accepts are combinational so the requester sees them in the grant cycle;
    // gated by reset so every output reads 0 while reset is held.
    assign o_a_accept = w_idle & w_grant_a & ~i_rst;
    assign o_b_accept = w_idle & w_grant_b & ~i_rst;

    assign o_a_done   = r_a_done;
    assign o_b_done   = r_b_done;
    assign o_a_rdata  = r_a_rdata;
    assign o_b_rdata  = r_b_rdata;
    assign o_advance  = r_advance;
    assign o_valid    = (r_state == S_ISSUE);
    assign o_rd_n_wr  = r_hold_rd_n_wr;
    assign o_addr     = r_hold_addr;
    assign o_wdata    = r_hold_wdata;
    assign o_busy     = ~w_idle;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed self-checking bench for sram_arb. A second instance at
// DIV=1 shares all inputs and is used only for its advance strobe.
module tb_sram_arb;

    logic        clk;
    logic        rst;
    logic        a_valid, a_rd_n_wr, b_valid, b_rd_n_wr;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        ctl_accept, ctl_ready;
    logic [7:0]  ctl_rdata;

    logic        a_accept, a_done, b_accept, b_done;
    logic [7:0]  a_rdata, b_rdata;
    logic        advance, valid, rd_n_wr, busy;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic        u1_a_accept, u1_a_done, u1_b_accept, u1_b_done;
    logic [7:0]  u1_a_rdata, u1_b_rdata;
    logic        u1_advance, u1_valid, u1_rd_n_wr, u1_busy;
    logic [15:0] u1_addr;
    logic [7:0]  u1_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    sram_arb #(.DIV(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_rd_n_wr(a_rd_n_wr), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_accept(a_accept), .o_a_done(a_done), .o_a_rdata(a_rdata),
        .i_b_valid(b_valid), .i_b_rd_n_wr(b_rd_n_wr), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_accept(b_accept), .o_b_done(b_done), .o_b_rdata(b_rdata),
        .o_advance(advance), .o_valid(valid), .i_accept(ctl_accept),
        .o_rd_n_wr(rd_n_wr), .o_addr(addr), .o_wdata(wdata),
        .i_ready(ctl_ready), .i_rdata(ctl_rdata), .o_busy(busy)
    );

    sram_arb #(.DIV(1)) dut_div1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_rd_n_wr(a_rd_n_wr), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_accept(u1_a_accept), .o_a_done(u1_a_done), .o_a_rdata(u1_a_rdata),
        .i_b_valid(b_valid), .i_b_rd_n_wr(b_rd_n_wr), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_accept(u1_b_accept), .o_b_done(u1_b_done), .o_b_rdata(u1_b_rdata),
        .o_advance(u1_advance), .o_valid(u1_valid), .i_accept(ctl_accept),
        .o_rd_n_wr(u1_rd_n_wr), .o_addr(u1_addr), .o_wdata(u1_wdata),
        .i_ready(ctl_ready), .i_rdata(ctl_rdata), .o_busy(u1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the controller until the arbiter goes idle: accepts whatever is
    // issued, answers reads with rd_val, and records which done pulses fired.
    task automatic drain(input logic [7:0] rd_val, output logic a_seen, output logic b_seen);
        a_seen = 1'b0;
        b_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            a_seen = a_seen | a_done;
            b_seen = b_seen | b_done;
            if (!busy) break;
            ctl_accept = valid;
            ctl_ready  = busy & ~valid;
            ctl_rdata  = rd_val;
        end
        ctl_accept = 1'b0;
        ctl_ready  = 1'b0;
        ctl_rdata  = '0;
        check("drain_idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic   a_seen, b_seen;
        int     prev, hi, hi1, g;
        logic   order [4];

        rst = 1'b1;
        a_valid = 0; a_rd_n_wr = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_rd_n_wr = 0; b_addr = '0; b_wdata = '0;
        ctl_accept = 0; ctl_ready = 0; ctl_rdata = '0;
        order = '{default: 1'b0};

        // ---- reset state
        repeat (3) tick();
        check("rst_advance", 32'(advance), 0);
        check("rst_advance_div1", 32'(u1_advance), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_rdata_a", 32'(a_rdata), 0);
        check("rst_rdata_b", 32'(b_rdata), 0);
        check("rst_done", 32'({a_done, b_done}), 0);
        a_valid = 1'b1;
        #1;
        check("rst_accept", 32'({a_accept, b_accept}), 0);
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---- advance strobe: one in four at DIV=4, constant at DIV=1
        prev = -1; hi = 0; hi1 = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (advance) begin
                if (prev >= 0) check("adv_gap", 32'(k - prev), 4);
                prev = k;
                hi++;
            end
            if (u1_advance) hi1++;
        end
        check("adv_count_div4", 32'(hi), 6);
        check("adv_count_div1", 32'(hi1), 24);

        // ---- single write from A, with a stray i_ready while in ISSUE
        tick();
        a_valid = 1; a_rd_n_wr = 0; a_addr = 16'h0123; a_wdata = 8'h5A;
        b_addr = 16'hBEEF;
        #1;
        check("wr_a_accept", 32'(a_accept), 1);
        check("wr_b_accept", 32'(b_accept), 0);
        tick();
        a_valid = 0; a_addr = 16'hFFFF; a_wdata = 8'h00;
        #1;
        check("wr_busy", 32'(busy), 1);
        check("wr_valid", 32'(valid), 1);
        check("wr_addr", 32'(addr), 'h0123);
        check("wr_wdata", 32'(wdata), 'h5A);
        check("wr_dir", 32'(rd_n_wr), 0);
        check("wr_no_second_accept", 32'(a_accept), 0);
        tick();
        ctl_ready = 1; ctl_rdata = 8'hEE;
        #1;
        tick();
        ctl_ready = 0; ctl_rdata = '0;
        #1;
        check("wr_stray_ready_valid", 32'(valid), 1);
        check("wr_stray_ready_done", 32'(a_done), 0);
        check("wr_stray_ready_rdata", 32'(a_rdata), 0);
        check("wr_hold_addr", 32'(addr), 'h0123);
        tick();
        ctl_accept = 1;
        #1;
        tick();
        ctl_accept = 0;
        #1;
        check("wr_a_done", 32'(a_done), 1);
        check("wr_b_done", 32'(b_done), 0);
        check("wr_idle", 32'(busy), 0);
        check("wr_valid_drop", 32'(valid), 0);
        tick();
        check("wr_a_done_once", 32'(a_done), 0);

        // ---- read-back from B, with a stray i_accept while in WAIT_RD
        b_valid = 1; b_rd_n_wr = 1; b_addr = 16'h0123;
        #1;
        check("rd_b_accept", 32'(b_accept), 1);
        check("rd_a_accept", 32'(a_accept), 0);
        tick();
        b_valid = 0;
        #1;
        check("rd_dir", 32'(rd_n_wr), 1);
        check("rd_addr", 32'(addr), 'h0123);
        tick();
        ctl_accept = 1;
        #1;
        tick();
        ctl_accept = 0;
        #1;
        check("rd_wait_valid", 32'(valid), 0);
        check("rd_wait_busy", 32'(busy), 1);
        tick();
        ctl_accept = 1;
        #1;
        tick();
        ctl_accept = 0;
        #1;
        check("rd_stray_accept_valid", 32'(valid), 0);
        check("rd_stray_accept_busy", 32'(busy), 1);
        check("rd_stray_accept_done", 32'(b_done), 0);
        tick();
        ctl_ready = 1; ctl_rdata = 8'h5A;
        #1;
        tick();
        ctl_ready = 0; ctl_rdata = '0;
        #1;
        check("rd_b_done", 32'(b_done), 1);
        check("rd_b_rdata", 32'(b_rdata), 'h5A);
        check("rd_a_done", 32'(a_done), 0);
        check("rd_a_rdata", 32'(a_rdata), 0);
        check("rd_idle", 32'(busy), 0);
        tick();
        check("rd_b_done_once", 32'(b_done), 0);
        check("rd_b_rdata_held", 32'(b_rdata), 'h5A);

        // ---- A raises and withdraws its request while B's write is in flight
        b_valid = 1; b_rd_n_wr = 0; b_addr = 16'h0042; b_wdata = 8'h11;
        #1;
        check("wd_b_accept", 32'(b_accept), 1);
        tick();
        b_valid = 0;
        a_valid = 1; a_rd_n_wr = 0; a_addr = 16'h0777; a_wdata = 8'h99;
        #1;
        check("wd_a_no_accept", 32'(a_accept), 0);
        check("wd_busy", 32'(busy), 1);
        tick();
        a_valid = 0;
        #1;
        check("wd_a_no_accept2", 32'(a_accept), 0);
        check("wd_busy2", 32'(busy), 1);
        check("wd_addr", 32'(addr), 'h0042);
        drain(8'h00, a_seen, b_seen);
        check("wd_b_done_seen", 32'(b_seen), 1);
        check("wd_a_done_seen", 32'(a_seen), 0);

        // ---- contention: both held valid for four grants (last grant was B)
        a_valid = 1; a_rd_n_wr = 0; a_addr = 16'h1000; a_wdata = 8'hA1;
        b_valid = 1; b_rd_n_wr = 0; b_addr = 16'h2000; b_wdata = 8'hB2;
        g = 0;
        for (int c = 0; c < 100 && g < 4; c++) begin
            if (c > 0) tick();
            ctl_accept = valid;
            #1;
            if (a_accept && b_accept) check("ct_dual_accept", 32'({a_accept, b_accept}), 'b01);
            if (a_accept) begin
                order[g] = 1'b0;
                g++;
            end else if (b_accept) begin
                order[g] = 1'b1;
                g++;
            end
        end
        tick();
        a_valid = 0; b_valid = 0;
        ctl_accept = valid;
        drain(8'h00, a_seen, b_seen);
        check("ct_grants", 32'(g), 4);
        check("ct_order0", 32'(order[0]), 0);
        check("ct_order1", 32'(order[1]), 1);
        check("ct_order2", 32'(order[2]), 0);
        check("ct_order3", 32'(order[3]), 1);

        // ---- reset while A's read waits for data
        tick();
        a_valid = 1; a_rd_n_wr = 1; a_addr = 16'h0200;
        #1;
        check("rr_a_accept", 32'(a_accept), 1);
        tick();
        a_valid = 0;
        ctl_accept = 1;
        #1;
        tick();
        ctl_accept = 0;
        #1;
        check("rr_wait_rd", 32'({busy, valid}), 'b10);
        tick();
        rst = 1;
        #1;
        check("rr_busy", 32'(busy), 0);
        check("rr_valid", 32'(valid), 0);
        check("rr_addr", 32'(addr), 0);
        check("rr_b_rdata", 32'(b_rdata), 0);
        check("rr_advance", 32'(advance), 0);
        tick();
        ctl_ready = 1; ctl_rdata = 8'h77;
        #1;
        check("rr_no_done", 32'({a_done, b_done}), 0);
        check("rr_a_rdata", 32'(a_rdata), 0);
        tick();
        ctl_ready = 0; ctl_rdata = '0;
        rst = 0;
        a_valid = 1; a_rd_n_wr = 0; a_addr = 16'h0300; a_wdata = 8'h33;
        b_valid = 1; b_rd_n_wr = 0; b_addr = 16'h0400; b_wdata = 8'h44;
        #1;
        check("rr_no_done_after", 32'({a_done, b_done}), 0);
        check("rr_ptr_a_first", 32'({a_accept, b_accept}), 'b10);
        tick();
        a_valid = 0;
        #1;
        check("rr_b_waits", 32'(b_accept), 0);
        check("rr_addr_new", 32'(addr), 'h0300);
        check("rr_wdata_new", 32'(wdata), 'h33);
        tick();
        ctl_accept = 1;
        #1;
        tick();
        ctl_accept = 0;
        #1;
        check("rr_a_done", 32'(a_done), 1);
        check("rr_b2b_accept", 32'(b_accept), 1);
        tick();
        b_valid = 0;
        #1;
        check("rr_b_addr", 32'(addr), 'h0400);
        drain(8'h00, a_seen, b_seen);
        check("rr_b_done_seen", 32'(b_seen), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
